first_stage_mac_accumulate: RTL and testbench
=============================================

# first_stage_mac_accumulate

Datapath stage directly downstream of the first-stage quadrant address generator. Consumes its per-tap stream (input address, filter address, B-element address, element-complete flag), fetches pixel and weight from synchronous-read memories, and forms saturating signed multiply-accumulates. On each element's last tap it writes one ReLU-shifted, saturated 8-bit result into the B-vector memory.

## Interface
- DATA_WIDTH, 8, pixel and weight width (pixel unsigned, weight signed two's complement)
- ACC_WIDTH, 24, signed accumulator width
- INPUT_ADDR_WIDTH, 12, input memory address width
- FILTER_ADDR_WIDTH, 8, filter memory address width
- B_ADDR_WIDTH, 9, B-vector memory address width
- SHIFT, 4, right shift applied before output saturation
- clock  in  1  sole clock, all state on rising edge
- clear  in  1  asynchronous, active-high reset
- en  in  1  stage enable; tap accepted only when en & input_address_ready
- input_address_ready  in  1  upstream tap valid
- input_address  in  INPUT_ADDR_WIDTH  pixel address for this tap
- filter_address  in  FILTER_ADDR_WIDTH  weight address for this tap
- b_element_requested  in  1  this tap is the last of the current element
- b_element_address  in  B_ADDR_WIDTH  destination of current element
- input_mem_addr  out  INPUT_ADDR_WIDTH  combinational copy of input_address
- input_mem_data  in  DATA_WIDTH  pixel, valid one cycle after address
- filter_mem_addr  out  FILTER_ADDR_WIDTH  combinational copy of filter_address
- filter_mem_data  in  DATA_WIDTH  weight, valid one cycle after address
- b_write  out  1  one-cycle write strobe
- b_write_address  out  B_ADDR_WIDTH  write address
- b_write_data  out  DATA_WIDTH  unsigned result
- elements_written  out  B_ADDR_WIDTH+1  count of b_write pulses since clear, wraps at max
- busy  out  1  any pipeline stage holds a valid tap

## Operation
- Three-stage pipeline; no backpressure, one tap per cycle accepted.
- S1 (T+1): capture valid, last flag, B address alongside returning memory data.
- S2 (T+2): register product = zero-extended pixel × signed weight (2·DATA_WIDTH+1 bits, signed).
- S3 (end of T+2): acc_next = first ? product : acc + product, sign-extended to ACC_WIDTH+1 then saturated to signed ACC_WIDTH range. acc <= acc_next.
- first flag: set at reset and after every accumulated last tap; cleared on accumulating a non-last tap. A last tap in the same cycle as a first tap (one-tap element) is legal: result = product.
- Output on last tap: result = acc_next ≤ 0 ? 0 : min(acc_next >>> SHIFT, 2^DATA_WIDTH−1).
- Invalid cycles (bubbles) inside an element leave acc and first untouched.
- en low: new taps ignored; in-flight taps still drain and write.

## Timing
- Tap accepted at cycle T → b_write high at T+3 for exactly one cycle if that tap was last.
- Back-to-back elements: writes spaced by element length; no dead cycle required between elements.
- Reset values: b_write 0, b_write_address 0, b_write_data 0, elements_written 0, busy 0, acc 0, first 1, all stage valids 0. Address outputs follow inputs.
- clear mid-element: partial sum discarded, no write produced, next accepted tap starts a new element.
- elements_written increments at the same edge that raises b_write; wraps 2^(B_ADDR_WIDTH+1)−1 → 0.

## Structure
- Package first_stage_pkg: width constants (DATA_WIDTH, ACC_WIDTH, address widths, SHIFT defaults), product width, ACC_MAX/ACC_MIN, OUT_MAX.
- Sub-module first_stage_saturating_mac: combinational product register input → saturated acc_next plus ReLU/shift/saturate result; top holds pipeline registers, first flag, counter.

## Test plan
- 9 taps, pixel 10, weight 1, last on tap 9, address 0x05, SHIFT 0 → b_write once at T9+3, address 0x05, data 90, elements_written 1.
- 9 taps pixel 255, weight 127, SHIFT 4 → acc 291465, shifted 18216 → data 255 (saturated).
- 9 taps pixel 200, weight −1 → acc −1800 → data 0 (ReLU).
- Two back-to-back 9-tap elements (pixel 1 weight 2, then pixel 3 weight 1) with no gap → writes 18 then 27, 9 cycles apart; second not polluted by first.
- Bubbles (en low two cycles) inside an element of pixel 5 weight 2 ×4 taps → data 40, written 3 cycles after the last tap.
- clear asserted after 5 of 9 taps, then a fresh 3-tap element pixel 2 weight 3 → single write, data 18; no write for aborted element; elements_written 1.

Source files
------------

// File: rtl/first_stage_mac_accumulate_pkg.sv
// Shared widths, saturation limits and pipeline control record for the
// first-stage multiply-accumulate datapath.
package first_stage_pkg;
  localparam int DATA_WIDTH        = 8;
  localparam int ACC_WIDTH         = 24;
  localparam int INPUT_ADDR_WIDTH  = 12;
  localparam int FILTER_ADDR_WIDTH = 8;
  localparam int B_ADDR_WIDTH      = 9;
  localparam int SHIFT_DEFAULT     = 4;

  localparam int PROD_WIDTH  = 2 * DATA_WIDTH + 1;
  localparam int COUNT_WIDTH = B_ADDR_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]       OUT_MAX = '1;

  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic [B_ADDR_WIDTH-1:0] b_addr;
  } tap_ctrl_t;
endpackage

// File: rtl/first_stage_mac_accumulate_if.sv
// Tap stream, memory read ports and B-vector write port of the MAC stage.
// A tap transfers on a rising edge when en & input_address_ready; there is no ready back to the source.
interface first_stage_mac_accumulate_if;
  import first_stage_pkg::*;

  logic                         en;
  logic                         input_address_ready;
  logic [INPUT_ADDR_WIDTH-1:0]  input_address;
  logic [FILTER_ADDR_WIDTH-1:0] filter_address;
  logic                         b_element_requested;
  logic [B_ADDR_WIDTH-1:0]      b_element_address;
  logic [INPUT_ADDR_WIDTH-1:0]  input_mem_addr;
  logic [DATA_WIDTH-1:0]        input_mem_data;
  logic [FILTER_ADDR_WIDTH-1:0] filter_mem_addr;
  logic [DATA_WIDTH-1:0]        filter_mem_data;
  logic                         b_write;
  logic [B_ADDR_WIDTH-1:0]      b_write_address;
  logic [DATA_WIDTH-1:0]        b_write_data;

  modport slave (
    input  en, input_address_ready, input_address, filter_address,
           b_element_requested, b_element_address, input_mem_data, filter_mem_data,
    output input_mem_addr, filter_mem_addr, b_write, b_write_address, b_write_data
  );

  modport master (
    output en, input_address_ready, input_address, filter_address,
           b_element_requested, b_element_address, input_mem_data, filter_mem_data,
    input  input_mem_addr, filter_mem_addr, b_write, b_write_address, b_write_data
  );
endinterface

// File: rtl/first_stage_saturating_mac.sv
// Combinational accumulate step: saturating signed add of the registered product,
// plus the ReLU / arithmetic shift / unsigned saturation of the result.
module first_stage_saturating_mac
  import first_stage_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic signed [PROD_WIDTH-1:0] product,
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic                         first,
  output logic signed [ACC_WIDTH-1:0]  acc_next,
  output logic [DATA_WIDTH-1:0]        result
);
  logic signed [ACC_WIDTH:0]   prod_ext;
  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    prod_ext = {{(ACC_WIDTH+1-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
    acc_ext  = {acc[ACC_WIDTH-1], acc};
    sum      = first ? prod_ext : acc_ext + prod_ext;

    // The extra top bit disagreeing with the sign bit means the 24-bit range was left.
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum[ACC_WIDTH-1:0];
    end

    shifted = acc_next >>> SHIFT;
    if (acc_next[ACC_WIDTH-1] || (acc_next == '0)) begin
      result = '0;
    end else if (|shifted[ACC_WIDTH-1:DATA_WIDTH]) begin
      result = OUT_MAX;
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/first_stage_mac_accumulate.sv
// Three-stage pixel x weight accumulate pipeline: S1 aligns tap control with memory data,
// S2 holds the product, S3 accumulates and emits one B-vector write per element.
module first_stage_mac_accumulate
  import first_stage_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic                   clock,
  input  logic                   clear,
  first_stage_mac_accumulate_if.slave bus,
  output logic [COUNT_WIDTH-1:0] elements_written,
  output logic                   busy
);
  tap_ctrl_t                    s1_q, s1_d, s2_q, s2_d;
  logic signed [PROD_WIDTH-1:0] product_q, product_d;
  logic signed [PROD_WIDTH-1:0] pixel_ext, weight_ext;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_next;
  logic                         first_q, first_d;
  logic [DATA_WIDTH-1:0]        result;
  logic                         b_write_q, b_write_d;
  logic [B_ADDR_WIDTH-1:0]      b_addr_q, b_addr_d;
  logic [DATA_WIDTH-1:0]        b_data_q, b_data_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;

  assign bus.input_mem_addr  = bus.input_address;
  assign bus.filter_mem_addr = bus.filter_address;

  first_stage_saturating_mac #(.SHIFT(SHIFT)) u_mac (
    .product  (product_q),
    .acc      (acc_q),
    .first    (first_q),
    .acc_next (acc_next),
    .result   (result)
  );

  always_comb begin
    s1_d.valid = bus.en & bus.input_address_ready;
    s1_d.last  = bus.b_element_requested;
    s1_d.b_addr = bus.b_element_address;
    s2_d = s1_q;

    // Pixels are unsigned, so zero-extend before the signed multiply.
    pixel_ext  = {{(PROD_WIDTH-DATA_WIDTH){1'b0}}, bus.input_mem_data};
    weight_ext = {{(PROD_WIDTH-DATA_WIDTH){bus.filter_mem_data[DATA_WIDTH-1]}}, bus.filter_mem_data};
    product_d  = pixel_ext * weight_ext;

    acc_d     = acc_q;
    first_d   = first_q;
    b_write_d = 1'b0;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    count_d   = count_q;
    if (s2_q.valid) begin
      acc_d   = acc_next;
      first_d = s2_q.last;
      if (s2_q.last) begin
        b_write_d = 1'b1;
        b_addr_d  = s2_q.b_addr;
        b_data_d  = result;
        count_d   = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1_q      <= '0;
      s2_q      <= '0;
      product_q <= '0;
      acc_q     <= '0;
      first_q   <= 1'b1;
      b_write_q <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      count_q   <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      b_write_q <= b_write_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      count_q   <= count_d;
    end
  end

  assign bus.b_write         = b_write_q;
  assign bus.b_write_address = b_addr_q;
  assign bus.b_write_data    = b_data_q;
  assign elements_written    = count_q;
  assign busy                = s1_q.valid | s2_q.valid;
endmodule

// File: tb/tb_first_stage_mac_accumulate.sv
// Directed bench for first_stage_mac_accumulate: a SHIFT=0 and a SHIFT=4 instance share
// one tap stream; writes are checked against an expected queue and for exact timing.
module tb_first_stage_mac_accumulate;
  import first_stage_pkg::*;

  localparam int W = B_ADDR_WIDTH + 2 * DATA_WIDTH;

  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  first_stage_mac_accumulate_if bus0 ();
  first_stage_mac_accumulate_if bus4 ();
  logic [COUNT_WIDTH-1:0] ew0, ew4;
  logic busy0, busy4;

  logic [DATA_WIDTH-1:0] in_mem [0:4095];
  logic [DATA_WIDTH-1:0] f_mem  [0:255];

  logic [W-1:0]           exp_q[$];
  int                     wr_time[$];
  logic [COUNT_WIDTH-1:0] wr_cnt[$];
  logic [COUNT_WIDTH-1:0] exp_written;
  int                     t_last;

  first_stage_mac_accumulate #(.SHIFT(0)) dut0 (
    .clock(clock), .clear(clear), .bus(bus0.slave), .elements_written(ew0), .busy(busy0)
  );
  first_stage_mac_accumulate #(.SHIFT(4)) dut4 (
    .clock(clock), .clear(clear), .bus(bus4.slave), .elements_written(ew4), .busy(busy4)
  );

  assign bus4.en                  = bus0.en;
  assign bus4.input_address_ready = bus0.input_address_ready;
  assign bus4.input_address       = bus0.input_address;
  assign bus4.filter_address      = bus0.filter_address;
  assign bus4.b_element_requested = bus0.b_element_requested;
  assign bus4.b_element_address   = bus0.b_element_address;

  // clock / reset block and synchronous-read memory models
  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    bus0.input_mem_data  <= in_mem[bus0.input_mem_addr];
    bus0.filter_mem_data <= f_mem[bus0.filter_mem_addr];
    bus4.input_mem_data  <= in_mem[bus4.input_mem_addr];
    bus4.filter_mem_data <= f_mem[bus4.filter_mem_addr];
  end

  // scoreboard
  always @(negedge clock) begin
    if (bus0.b_write === 1'b1) begin
      logic [W-1:0] exp_v, got_v;
      got_v = {bus0.b_write_address, bus0.b_write_data, bus4.b_write_data};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_write: got %h expected no write", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL sb_write: got addr %h data %0d data4 %0d expected addr %h data %0d data4 %0d",
                   got_v[W-1 -: B_ADDR_WIDTH], got_v[2*DATA_WIDTH-1 -: DATA_WIDTH], got_v[DATA_WIDTH-1:0],
                   exp_v[W-1 -: B_ADDR_WIDTH], exp_v[2*DATA_WIDTH-1 -: DATA_WIDTH], exp_v[DATA_WIDTH-1:0]);
        end
      end
      wr_time.push_back(cyc);
      wr_cnt.push_back(ew0);
    end
  end

  // driver tasks
  task automatic drive_idle();
    @(negedge clock);
    bus0.en = 1'b1;
    bus0.input_address_ready = 1'b0;
    bus0.b_element_requested = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) drive_idle();
  endtask

  task automatic send_tap(input logic [INPUT_ADDR_WIDTH-1:0] ia, input logic [FILTER_ADDR_WIDTH-1:0] fa,
                          input logic last, input logic [B_ADDR_WIDTH-1:0] ba, input logic en_v);
    @(negedge clock);
    bus0.en                  = en_v;
    bus0.input_address_ready = 1'b1;
    bus0.input_address       = ia;
    bus0.filter_address      = fa;
    bus0.b_element_requested = last;
    bus0.b_element_address   = ba;
    if (last && en_v) t_last = cyc;
  endtask

  task automatic run_element(input int base, input int n, input logic [B_ADDR_WIDTH-1:0] ba);
    for (int i = 0; i < n; i++) send_tap(12'(base + i), 8'(base + i), (i == n - 1), ba, 1'b1);
  endtask

  task automatic fill(input int base, input int n, input logic [7:0] pix, input logic [7:0] w);
    for (int i = 0; i < n; i++) begin
      in_mem[base + i] = pix;
      f_mem[base + i]  = w;
    end
  endtask

  task automatic expect_write(input logic [8:0] ba, input logic [7:0] d0, input logic [7:0] d4);
    exp_q.push_back({ba, d0, d4});
    exp_written = exp_written + 1'b1;
  endtask

  // tests
  task automatic test_reset();
    clear = 1'b1;
    bus0.en = 1'b0;
    bus0.input_address_ready = 1'b0;
    bus0.input_address = 12'h123;
    bus0.filter_address = 8'h45;
    bus0.b_element_requested = 1'b0;
    bus0.b_element_address = '0;
    @(negedge clock);
    @(negedge clock);
    tests_run++; if (bus0.b_write !== 1'b0) begin tests_failed++; $display("FAIL reset_b_write: got %b expected 0", bus0.b_write); end
    tests_run++; if (bus0.b_write_address !== 9'h000) begin tests_failed++; $display("FAIL reset_b_addr: got %h expected 000", bus0.b_write_address); end
    tests_run++; if (bus0.b_write_data !== 8'h00) begin tests_failed++; $display("FAIL reset_b_data: got %h expected 00", bus0.b_write_data); end
    tests_run++; if (ew0 !== 10'd0 || ew4 !== 10'd0) begin tests_failed++; $display("FAIL reset_written: got %0d/%0d expected 0", ew0, ew4); end
    tests_run++; if (busy0 !== 1'b0 || busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b/%b expected 0", busy0, busy4); end
    tests_run++; if (bus0.input_mem_addr !== 12'h123) begin tests_failed++; $display("FAIL input_mem_addr: got %h expected 123", bus0.input_mem_addr); end
    tests_run++; if (bus0.filter_mem_addr !== 8'h45) begin tests_failed++; $display("FAIL filter_mem_addr: got %h expected 45", bus0.filter_mem_addr); end
    clear = 1'b0;
    exp_written = '0;
  endtask

  task automatic test_single();
    fill(0, 9, 8'd10, 8'd1);
    wr_time.delete(); wr_cnt.delete();
    expect_write(9'h005, 8'd90, 8'd5);
    run_element(0, 9, 9'h005);
    tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b expected 1", busy0); end
    drain(6);
    tests_run++; if (wr_time.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d writes expected 1", wr_time.size()); end
    tests_run++; if (wr_time.size() > 0 && wr_time[0] - t_last != 3) begin tests_failed++; $display("FAIL single_latency: got %0d expected 3", wr_time[0] - t_last); end
    tests_run++; if (wr_cnt.size() > 0 && wr_cnt[0] !== 10'd1) begin tests_failed++; $display("FAIL single_written_at_write: got %0d expected 1", wr_cnt[0]); end
    tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL single_idle_busy: got %b expected 0", busy0); end
    tests_run++; if (bus0.b_write !== 1'b0) begin tests_failed++; $display("FAIL single_strobe_width: got %b expected 0", bus0.b_write); end
  endtask

  task automatic test_saturate();
    fill(16, 9, 8'd255, 8'd127);
    wr_time.delete(); wr_cnt.delete();
    expect_write(9'h0A0, 8'd255, 8'd255);
    run_element(16, 9, 9'h0A0);
    drain(6);
    tests_run++; if (wr_time.size() != 1) begin tests_failed++; $display("FAIL saturate_count: got %0d writes expected 1", wr_time.size()); end
    tests_run++; if (ew0 !== 10'd2) begin tests_failed++; $display("FAIL saturate_written: got %0d expected 2", ew0); end
  endtask

  task automatic test_relu();
    fill(32, 9, 8'd200, 8'hFF);
    wr_time.delete(); wr_cnt.delete();
    expect_write(9'h1FF, 8'd0, 8'd0);
    run_element(32, 9, 9'h1FF);
    drain(6);
    tests_run++; if (wr_time.size() != 1) begin tests_failed++; $display("FAIL relu_count: got %0d writes expected 1", wr_time.size()); end
    tests_run++; if (ew0 !== 10'd3) begin tests_failed++; $display("FAIL relu_written: got %0d expected 3", ew0); end
  endtask

  task automatic test_back_to_back();
    int t_a;
    fill(48, 9, 8'd1, 8'd2);
    fill(64, 9, 8'd3, 8'd1);
    wr_time.delete(); wr_cnt.delete();
    expect_write(9'h011, 8'd18, 8'd1);
    expect_write(9'h012, 8'd27, 8'd1);
    run_element(48, 9, 9'h011);
    t_a = t_last;
    run_element(64, 9, 9'h012);
    drain(6);
    tests_run++; if (wr_time.size() != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d writes expected 2", wr_time.size()); end
    tests_run++; if (wr_time.size() > 0 && wr_time[0] - t_a != 3) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected 3", wr_time[0] - t_a); end
    tests_run++; if (wr_time.size() > 1 && wr_time[1] - wr_time[0] != 9) begin tests_failed++; $display("FAIL b2b_spacing: got %0d expected 9", wr_time[1] - wr_time[0]); end
    tests_run++; if (ew0 !== 10'd5) begin tests_failed++; $display("FAIL b2b_written: got %0d expected 5", ew0); end
  endtask

  task automatic test_bubbles();
    fill(80, 4, 8'd5, 8'd2);
    in_mem[200] = 8'd99;
    f_mem[200]  = 8'd99;
    wr_time.delete(); wr_cnt.delete();
    expect_write(9'h033, 8'd40, 8'd2);
    send_tap(12'd80, 8'd80, 1'b0, 9'h033, 1'b1);
    send_tap(12'd81, 8'd81, 1'b0, 9'h033, 1'b1);
    send_tap(12'd200, 8'd200, 1'b1, 9'h1EE, 1'b0);
    send_tap(12'd200, 8'd200, 1'b1, 9'h1EE, 1'b0);
    send_tap(12'd82, 8'd82, 1'b0, 9'h033, 1'b1);
    send_tap(12'd83, 8'd83, 1'b1, 9'h033, 1'b1);
    drain(6);
    tests_run++; if (wr_time.size() != 1) begin tests_failed++; $display("FAIL bubble_count: got %0d writes expected 1", wr_time.size()); end
    tests_run++; if (wr_time.size() > 0 && wr_time[0] - t_last != 3) begin tests_failed++; $display("FAIL bubble_latency: got %0d expected 3", wr_time[0] - t_last); end
  endtask

  task automatic test_clear_mid();
    fill(96, 9, 8'd100, 8'd100);
    fill(112, 3, 8'd2, 8'd3);
    wr_time.delete(); wr_cnt.delete();
    for (int i = 0; i < 5; i++) send_tap(12'(96 + i), 8'(96 + i), 1'b0, 9'h0AA, 1'b1);
    @(negedge clock);
    clear = 1'b1;
    bus0.input_address_ready = 1'b0;
    @(negedge clock);
    tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL clear_busy: got %b expected 0", busy0); end
    tests_run++; if (ew0 !== 10'd0) begin tests_failed++; $display("FAIL clear_written: got %0d expected 0", ew0); end
    clear = 1'b0;
    exp_written = '0;
    expect_write(9'h1AB, 8'd18, 8'd1);
    run_element(112, 3, 9'h1AB);
    drain(6);
    tests_run++; if (wr_time.size() != 1) begin tests_failed++; $display("FAIL clear_count: got %0d writes expected 1", wr_time.size()); end
    tests_run++; if (wr_time.size() > 0 && wr_time[0] - t_last != 3) begin tests_failed++; $display("FAIL clear_latency: got %0d expected 3", wr_time[0] - t_last); end
    tests_run++; if (ew0 !== 10'd1) begin tests_failed++; $display("FAIL clear_new_written: got %0d expected 1", ew0); end
  endtask

  task automatic test_wrap();
    int n;
    fill(128, 1, 8'd3, 8'd4);
    wr_time.delete(); wr_cnt.delete();
    for (int i = 0; i < 1023; i++) begin
      expect_write(9'(i), 8'd12, 8'd0);
      send_tap(12'd128, 8'd128, 1'b1, 9'(i), 1'b1);
    end
    drain(6);
    n = wr_cnt.size();
    tests_run++; if (n != 1023) begin tests_failed++; $display("FAIL wrap_count: got %0d writes expected 1023", n); end
    tests_run++; if (n > 1 && wr_cnt[n-2] !== 10'd1023) begin tests_failed++; $display("FAIL wrap_max: got %0d expected 1023", wr_cnt[n-2]); end
    tests_run++; if (n > 0 && wr_cnt[n-1] !== 10'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d expected 0", wr_cnt[n-1]); end
    tests_run++; if (ew0 !== exp_written || ew4 !== exp_written) begin tests_failed++; $display("FAIL wrap_final: got %0d/%0d expected %0d", ew0, ew4, exp_written); end
    tests_run++; if (n > 0 && wr_time[n-1] - t_last != 3) begin tests_failed++; $display("FAIL wrap_latency: got %0d expected 3", wr_time[n-1] - t_last); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) in_mem[i] = '0;
    for (int i = 0; i < 256; i++) f_mem[i] = '0;
    t_last = 0;
    test_reset();
    test_single();
    test_saturate();
    test_relu();
    test_back_to_back();
    test_bubbles();
    test_clear_mid();
    test_wrap();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending writes expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
